// File: rtl/adder_key_loader.sv
// Serial key loader and operand stager for the XOR-key-locked 16-bit adder.
// The adder sees an all-zero key until a key passes its trailing even-parity check.
module adder_key_loader #(
  parameter int KEY_W = 32,
  parameter int OP_W  = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_start_i,
  input  logic            key_bit_i,
  input  logic            key_bit_valid_i,
  input  logic [OP_W-1:0] add1_i,
  input  logic [OP_W-1:0] add2_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  output logic [KEY_W-1:0] key_o,
  output logic            key_valid_o,
  output logic            busy_o,
  output logic            key_err_o,
  output logic [OP_W-1:0] add1_o,
  output logic [OP_W-1:0] add2_o,
  output logic            op_valid_o
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, READY, ERROR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [KEY_W-1:0]   shift_q;
  logic               parity_q;

  // A restart wins over everything, so key_o never carries a partial or stale key.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      key_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else if (load_start_i) begin
      state       <= SHIFT;
      bit_cnt     <= '0;
      shift_q     <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      key_err_o   <= 1'b0;
      busy_o      <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (key_bit_valid_i) begin
            if (bit_cnt == CNT_W'(KEY_W)) begin
              parity_q <= key_bit_i;
              state    <= CHECK;
            end else begin
              shift_q <= {shift_q[KEY_W-2:0], key_bit_i};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          busy_o <= 1'b0;
          if (^{shift_q, parity_q} == 1'b0) begin
            key_o       <= shift_q;
            key_valid_o <= 1'b1;
            state       <= READY;
          end else begin
            key_err_o <= 1'b1;
            state     <= ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_ready_o = key_valid_o;

  // Operand staging: one pair per cycle, registers hold between handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add1_o     <= '0;
      add2_o     <= '0;
      op_valid_o <= 1'b0;
    end else begin
      op_valid_o <= op_valid_i && key_valid_o;
      if (op_valid_i && key_valid_o) begin
        add1_o <= add1_i;
        add2_o <= add2_i;
      end
    end
  end

endmodule
